// File: rtl/count64_pkg.sv
// Shared types and constants for the 64-bit counter reader.
`timescale 1ns/1ps
package count64_pkg;

    localparam int DEF_BUS_W = 32;
    localparam int DEF_CNT_W = 2 * DEF_BUS_W;

    localparam logic ADDR_LO = 1'b0;
    localparam logic ADDR_HI = 1'b1;

    localparam logic [DEF_CNT_W-1:0] CMP_RST = '1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } rd_state_t;

endpackage

// File: rtl/count64_cmp.sv
// Compare register pair with one-shot arming and a sticky alarm.
`timescale 1ns/1ps
module count64_cmp
    import count64_pkg::*;
#(
    parameter int BUS_W = DEF_BUS_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [CNT_W-1:0] Count,
    input  logic             Cmp_Wr,
    input  logic             Cmp_Addr,
    input  logic [BUS_W-1:0] Cmp_Data,
    input  logic             Alarm_Clr,
    output logic             Alarm
);

    logic [BUS_W-1:0] cmp_stage;
    logic [CNT_W-1:0] cmp_val;
    logic             armed;
    logic             match;

    // Unsigned compare; a wrapped count simply keeps waiting.
    assign match = armed && (Count >= cmp_val);

    // LO half is staged so the active value only changes as one 64-bit commit.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cmp_stage <= '0;
            cmp_val   <= CMP_RST;
        end else if (Cmp_Wr) begin
            if (Cmp_Addr == ADDR_LO)
                cmp_stage <= Cmp_Data;
            else
                cmp_val <= {Cmp_Data, cmp_stage};
        end
    end

    // Match disarms so the alarm fires once per commit; a commit re-arms.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            armed <= 1'b0;
        else if (Cmp_Wr && Cmp_Addr == ADDR_HI)
            armed <= 1'b1;
        else if (match)
            armed <= 1'b0;
    end

    // Sticky alarm; a simultaneous set beats the clear.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            Alarm <= 1'b0;
        else if (match)
            Alarm <= 1'b1;
        else if (Alarm_Clr)
            Alarm <= 1'b0;
    end

endmodule

// File: rtl/count64_reader.sv
// Coherent two-word bus read of the 64-bit cycle counter plus compare alarm.
`timescale 1ns/1ps
module count64_reader
    import count64_pkg::*;
#(
    parameter int BUS_W = DEF_BUS_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [CNT_W-1:0] Count,
    input  logic             Rd_Req,
    input  logic             Rd_Addr,
    output logic             Rd_Ready,
    output logic             Rd_Ack,
    output logic [BUS_W-1:0] Rd_Data,
    input  logic             Cmp_Wr,
    input  logic             Cmp_Addr,
    input  logic [BUS_W-1:0] Cmp_Data,
    output logic             Alarm,
    input  logic             Alarm_Clr
);

    rd_state_t        state, state_nxt;
    logic             accept;
    // Only the high half of the snapshot is ever returned later; the low
    // half goes straight to Rd_Data at snapshot time.
    logic [BUS_W-1:0] snap_hi;
    logic             hi_valid;

    // State register for the read handshake.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state and handshake outputs; requests during RESP are dropped.
    always_comb begin
        state_nxt = state;
        Rd_Ready  = 1'b0;
        Rd_Ack    = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                Rd_Ready = 1'b1;
                accept   = Rd_Req;
                if (Rd_Req) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                Rd_Ack    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // LO read snapshots; HI read uses the snapshot once, else reads live.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Rd_Data  <= '0;
            snap_hi  <= '0;
            hi_valid <= 1'b0;
        end else if (accept) begin
            if (Rd_Addr == ADDR_LO) begin
                snap_hi  <= Count[CNT_W-1:BUS_W];
                Rd_Data  <= Count[BUS_W-1:0];
                hi_valid <= 1'b1;
            end else if (hi_valid) begin
                Rd_Data  <= snap_hi;
                hi_valid <= 1'b0;
            end else begin
                snap_hi  <= Count[CNT_W-1:BUS_W];
                Rd_Data  <= Count[CNT_W-1:BUS_W];
            end
        end
    end

    count64_cmp #(.BUS_W(BUS_W), .CNT_W(CNT_W)) u_cmp (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Count     (Count),
        .Cmp_Wr    (Cmp_Wr),
        .Cmp_Addr  (Cmp_Addr),
        .Cmp_Data  (Cmp_Data),
        .Alarm_Clr (Alarm_Clr),
        .Alarm     (Alarm)
    );

endmodule

// File: tb/tb_count64_reader.sv
// Directed self-checking bench for count64_reader.
`timescale 1ns/1ps
module tb_count64_reader;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [63:0] Count = '0;
    logic        Rd_Req = 1'b0;
    logic        Rd_Addr = 1'b0;
    logic        Rd_Ready;
    logic        Rd_Ack;
    logic [31:0] Rd_Data;
    logic        Cmp_Wr = 1'b0;
    logic        Cmp_Addr = 1'b0;
    logic [31:0] Cmp_Data = '0;
    logic        Alarm;
    logic        Alarm_Clr = 1'b0;

    logic        run = 1'b0;
    int          errors = 0;
    int          checks = 0;

    count64_reader dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Count     (Count),
        .Rd_Req    (Rd_Req),
        .Rd_Addr   (Rd_Addr),
        .Rd_Ready  (Rd_Ready),
        .Rd_Ack    (Rd_Ack),
        .Rd_Data   (Rd_Data),
        .Cmp_Wr    (Cmp_Wr),
        .Cmp_Addr  (Cmp_Addr),
        .Cmp_Data  (Cmp_Data),
        .Alarm     (Alarm),
        .Alarm_Clr (Alarm_Clr)
    );

    always #5 Clk = ~Clk;

    // One clock edge; inputs change 1ns after it, the counter advances if running.
    task automatic tick;
        @(posedge Clk);
        #1;
        if (run) Count = Count + 64'd1;
    endtask

    task automatic do_reset;
        @(negedge Clk);
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        tick();
        checks++; if (Rd_Ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", Rd_Ready); end
        checks++; if (Rd_Ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", Rd_Ack); end
        checks++; if (Rd_Data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 00000000", Rd_Data); end
        checks++; if (Alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm got %b want 0", Alarm); end
    endtask

    task automatic test_coherent_read;
        Count = 64'h0000_0001_FFFF_FFFE;
        run = 1'b1;
        Rd_Req = 1'b1; Rd_Addr = 1'b0;
        tick();
        Rd_Req = 1'b0;
        checks++; if (Rd_Ack !== 1'b1) begin errors++; $display("FAIL lo_ack got %b want 1", Rd_Ack); end
        checks++; if (Rd_Data !== 32'hFFFF_FFFE) begin errors++; $display("FAIL lo_data got %h want fffffffe", Rd_Data); end
        tick();
        Rd_Req = 1'b1; Rd_Addr = 1'b1;
        tick();
        Rd_Req = 1'b0;
        checks++; if (Rd_Ack !== 1'b1) begin errors++; $display("FAIL hi_ack got %b want 1", Rd_Ack); end
        checks++; if (Rd_Data !== 32'h0000_0001) begin errors++; $display("FAIL hi_snap_data got %h want 00000001", Rd_Data); end
        run = 1'b0;
        tick();
    endtask

    task automatic test_hi_fresh;
        // A LO snapshot taken before reset must not survive it.
        Count = 64'hAAAA_AAAA_5555_5555;
        Rd_Req = 1'b1; Rd_Addr = 1'b0;
        tick();
        Rd_Req = 1'b0;
        do_reset();
        Count = 64'h1234_5678_9ABC_DEF0;
        Rd_Req = 1'b1; Rd_Addr = 1'b1;
        tick();
        Rd_Req = 1'b0;
        checks++; if (Rd_Data !== 32'h1234_5678) begin errors++; $display("FAIL hi_fresh got %h want 12345678", Rd_Data); end
        tick();
        // Hi_Valid stayed 0, so a second HI read samples live again.
        Count = 64'h5555_0000_0000_0001;
        Rd_Req = 1'b1; Rd_Addr = 1'b1;
        tick();
        Rd_Req = 1'b0;
        checks++; if (Rd_Data !== 32'h5555_0000) begin errors++; $display("FAIL hi_fresh2 got %h want 55550000", Rd_Data); end
        tick();
    endtask

    task automatic test_reset_mid_resp;
        Count = 64'h0000_0000_0000_0042;
        Rd_Req = 1'b1; Rd_Addr = 1'b0;
        tick();
        Rd_Req = 1'b0;
        checks++; if (Rd_Ack !== 1'b1) begin errors++; $display("FAIL midresp_ack_pre got %b want 1", Rd_Ack); end
        #2 Rst_n = 1'b0;
        #1;
        checks++; if (Rd_Ack !== 1'b0) begin errors++; $display("FAIL midresp_ack_rst got %b want 0", Rd_Ack); end
        checks++; if (Rd_Data !== 32'h0) begin errors++; $display("FAIL midresp_data_rst got %h want 00000000", Rd_Data); end
        @(negedge Clk);
        Rst_n = 1'b1;
        tick();
        checks++; if (Rd_Ack !== 1'b0 || Rd_Ready !== 1'b1) begin
            errors++; $display("FAIL midresp_post ack=%b ready=%b want ack=0 ready=1", Rd_Ack, Rd_Ready);
        end
    endtask

    task automatic test_back_to_back;
        int acks = 0;
        logic exp_ready;
        Count = 64'h0000_0000_0000_0007;
        Rd_Req = 1'b1; Rd_Addr = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (Rd_Ack === 1'b1) acks++;
            exp_ready = (i % 2 == 0);
            checks++; if (Rd_Ready !== exp_ready) begin
                errors++; $display("FAIL b2b_ready cycle %0d got %b want %b", i, Rd_Ready, exp_ready);
            end
        end
        Rd_Req = 1'b0;
        checks++; if (acks != 3) begin errors++; $display("FAIL b2b_acks got %0d want 3", acks); end
        tick();
    endtask

    task automatic test_alarm_match;
        logic [63:0] sampled;
        logic [63:0] fire_at = '0;
        logic        fired = 1'b0;
        do_reset();
        Count = '0; run = 1'b0;
        Cmp_Wr = 1'b1; Cmp_Addr = 1'b0; Cmp_Data = 32'h0000_0010;
        tick();
        Cmp_Addr = 1'b1; Cmp_Data = 32'h0;
        tick();
        Cmp_Wr = 1'b0;
        run = 1'b1;
        for (int i = 0; i < 40 && !fired; i++) begin
            sampled = Count;
            tick();
            if (Alarm === 1'b1) begin fired = 1'b1; fire_at = sampled; end
        end
        checks++; if (!fired) begin errors++; $display("FAIL alarm_timeout alarm never rose want at count 16"); end
        checks++; if (fired && fire_at !== 64'd16) begin errors++; $display("FAIL alarm_edge got count %0d want 16", fire_at); end
        Alarm_Clr = 1'b1;
        tick();
        Alarm_Clr = 1'b0;
        checks++; if (Alarm !== 1'b0) begin errors++; $display("FAIL alarm_clr got %b want 0", Alarm); end
        tick(); tick(); tick();
        checks++; if (Alarm !== 1'b0) begin errors++; $display("FAIL alarm_refire got %b want 0", Alarm); end
        run = 1'b0;
    endtask

    task automatic test_alarm_past;
        Count = 64'd100; run = 1'b0;
        Cmp_Wr = 1'b1; Cmp_Addr = 1'b0; Cmp_Data = 32'd5;
        tick();
        Cmp_Addr = 1'b1; Cmp_Data = 32'd0;
        tick();
        Cmp_Wr = 1'b0;
        checks++; if (Alarm !== 1'b0) begin errors++; $display("FAIL past_commit_edge got %b want 0", Alarm); end
        tick();
        checks++; if (Alarm !== 1'b1) begin errors++; $display("FAIL past_fire got %b want 1", Alarm); end
        // Clear and re-arm together; hold the clear into the match edge.
        Alarm_Clr = 1'b1;
        Cmp_Wr = 1'b1; Cmp_Addr = 1'b1; Cmp_Data = 32'd0;
        tick();
        Cmp_Wr = 1'b0;
        tick();
        Alarm_Clr = 1'b0;
        checks++; if (Alarm !== 1'b1) begin errors++; $display("FAIL set_wins got %b want 1", Alarm); end
    endtask

    initial begin
        test_reset();
        test_coherent_read();
        test_hi_fresh();
        test_reset_mid_resp();
        test_back_to_back();
        test_alarm_match();
        test_alarm_past();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
